frame_capture_ctrl: RTL and testbench
=====================================

// Module: frame_capture_ctrl
// PURPOSE
//  Snapshot controller between the pixel-recovery stage and the single-port frame BRAM.
//  On request, it aligns to the next frame boundary, writes one full frame
//  (addr = vcount*WIDTH + hcount), then freezes the buffer for the QR decoder.
//  Camera writes and decoder reads share the one BRAM port; writes have absolute priority.
// PARAMETERS
//  WIDTH           480      pixels per line
//  HEIGHT          320      lines per frame
//  ADDR_W          18       BRAM address width (>= clog2(WIDTH*HEIGHT))
//  RD_LAT          2        BRAM read latency, cycles (>=1)
//  TIMEOUT_CYCLES  2000000  watchdog limit (only with CAPTURE_TIMEOUT_EN)
// PORTS
//  system_clk_in      in   1       system clock
//  rst_in             in   1       asynchronous reset, active-high
//  capture_req_in     in   1       pulse: request a snapshot
//  release_in         in   1       pulse: decoder finished, free the buffer
//  frame_done_in      in   1       frame boundary pulse
//  data_valid_in      in   1       recovered pixel strobe
//  pixel_in           in   16      recovered pixel
//  hcount_in          in   11      pixel column
//  vcount_in          in   10      pixel row
//  rd_req_in          in   1       decoder read request
//  rd_addr_in         in   ADDR_W  decoder read address
//  rd_grant_out       out  1       read accepted this cycle (combinational)
//  rd_data_valid_out  out  1       rd_data_out valid, RD_LAT cycles after grant
//  rd_data_out        out  16      read data (= mem_dout_in)
//  mem_addr_out       out  ADDR_W  BRAM address
//  mem_we_out         out  1       BRAM write enable
//  mem_din_out        out  16      BRAM write data
//  mem_dout_in        in   16      BRAM read data
//  state_out          out  2       0 IDLE, 1 ARMED, 2 CAPTURE, 3 HOLD
//  frame_ready_out    out  1       high while in HOLD
//  short_frame_out    out  1       last capture wrote < WIDTH*HEIGHT pixels
//  timeout_out        out  1       1-cycle watchdog pulse
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, write stage, read-valid shift register and counters cleared.
//    A reset during CAPTURE abandons the frame; no further writes occur.
//  - FSM, registered:
//    - IDLE: capture_req_in -> ARMED.
//    - ARMED: frame_done_in -> CAPTURE, so capture starts on a clean frame.
//    - CAPTURE: frame_done_in -> HOLD. Latch short_frame_out = (pix_cnt != WIDTH*HEIGHT).
//    - HOLD: release_in -> IDLE. frame_done_in and capture_req_in are ignored.
//  - capture_req_in outside IDLE is ignored. A frame_done_in in IDLE is ignored.
//  - Write stage, 1 register:
//    - In CAPTURE, when data_valid_in && hcount_in<WIDTH && vcount_in<HEIGHT,
//      capture we_pend=1, addr, and pixel.
//    - Out-of-range pixels are dropped and not counted.
//    - Next cycle: mem_we_out=1, mem_addr_out=stage addr. Write latency is 1 cycle.
//    - A data_valid_in on the same cycle as frame_done_in is not written.
//  - Address math: vcount_in*WIDTH + hcount_in, evaluated at ADDR_W bits; no overflow for legal coordinates.
//  - pix_cnt: ADDR_W+1 bits, cleared on ARMED->CAPTURE, +1 per accepted write, saturates.
//  - Arbitration:
//    - rd_grant_out = rd_req_in & ~we_pend.
//    - When granted, mem_addr_out=rd_addr_in and mem_we_out=0.
//    - No queuing; the decoder re-asserts until granted. Reads are legal in any state.
//    - A HOLD-state read is never blocked.
//  - rd_data_valid_out: RD_LAT-deep shift of rd_grant_out.
//  - rd_data_out = mem_dout_in, passed through.
//  - frame_ready_out = (state==HOLD), registered with the state.
// CONFIGURATION
//  CAPTURE_TIMEOUT_EN defined:
//   - A 32-bit counter runs in ARMED/CAPTURE and clears on each state change.
//   - At TIMEOUT_CYCLES: state -> IDLE, timeout_out pulses 1 cycle, write stage cleared.
//   - A frame_done_in on the same cycle as the timeout wins (normal transition, no timeout).
//  CAPTURE_TIMEOUT_EN undefined: no counter, timeout_out tied 0.
// TESTING
//  1. Reset mid-CAPTURE -> state_out=0, mem_we_out=0 next cycle, no writes until a new request.
//  2. Capture flow, WIDTH=4, HEIGHT=2:
//     - Stimulus: capture_req, frame_done, 8 valid pixels 0x0100+i, frame_done.
//     - Response: writes to addr 0..7 one cycle after each strobe; HOLD; frame_ready=1; short_frame=0.
//  3. rd_req held while a write is pending -> rd_grant_out=0 that cycle, 1 the next.
//     - Read of addr 5 in HOLD returns 0x0105 exactly RD_LAT cycles after grant.
//  4. Only 6 pixels, and hcount_in=4 (out of range) strobed, before frame_done
//     -> out-of-range pixel not written, short_frame_out=1.
//  5. In HOLD: capture_req and frame_done same cycle -> stays HOLD.
//     - release_in -> IDLE, frame_ready_out=0.
//  6. CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=50, ARMED with no frame_done
//     -> timeout_out pulse at cycle 50, state IDLE.
//     - Repeat with frame_done at cycle 50 -> CAPTURE, no pulse.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: snapshot controller between pixel recovery and a single-port frame BRAM.
// On request it waits for the next frame boundary. It then writes one full frame at
// addr = vcount*WIDTH + hcount and freezes the buffer until the decoder releases it.
// Camera writes always win the shared BRAM port. Decoder reads are granted only when
// no write is pending.
// Optional build macro: CAPTURE_TIMEOUT_EN adds a watchdog on ARMED/CAPTURE. Without it,
// timeout_out is tied low.
// Ports:
//   system_clk_in, rst_in (async, active-high)
//   capture_req_in, release_in, frame_done_in          control pulses
//   data_valid_in, pixel_in, hcount_in, vcount_in      recovered pixel stream
//   rd_req_in, rd_addr_in -> rd_grant_out, rd_data_valid_out, rd_data_out
//   mem_addr_out, mem_we_out, mem_din_out, mem_dout_in BRAM port
//   state_out, frame_ready_out, short_frame_out, timeout_out  status
module frame_capture_ctrl #(
    parameter int unsigned WIDTH          = 480,
    parameter int unsigned HEIGHT         = 320,
    parameter int unsigned ADDR_W         = 18,
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic              system_clk_in,
    input  logic              rst_in,
    input  logic              capture_req_in,
    input  logic              release_in,
    input  logic              frame_done_in,
    input  logic              data_valid_in,
    input  logic [15:0]       pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              rd_req_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_grant_out,
    output logic              rd_data_valid_out,
    output logic [15:0]       rd_data_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [15:0]       mem_din_out,
    input  logic [15:0]       mem_dout_in,
    output logic [1:0]        state_out,
    output logic              frame_ready_out,
    output logic              short_frame_out,
    output logic              timeout_out
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FRAME_PIX = CNT_W'(WIDTH * HEIGHT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [10:0]       WIDTH_H   = 11'(WIDTH);
    localparam logic [9:0]        HEIGHT_V  = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               frame_ready_q, frame_ready_d;
    logic               short_q, short_d;
    logic               we_pend_q, we_pend_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [RD_LAT-1:0]  rd_vld_q, rd_vld_d;
    logic               pix_ok;
    logic [ADDR_W-1:0]  pix_addr;
`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // In-range pixel strobe and its raster address
    assign pix_ok   = data_valid_in && (hcount_in < WIDTH_H) && (vcount_in < HEIGHT_V);
    assign pix_addr = ADDR_W'(vcount_in) * WIDTH_A + ADDR_W'(hcount_in);

    // Port arbitration: a staged write owns the port this cycle
    assign rd_grant_out = rd_req_in & ~we_pend_q;
    assign mem_we_out   = we_pend_q;
    assign mem_addr_out = we_pend_q ? wr_addr_q : (rd_grant_out ? rd_addr_in : '0);
    assign mem_din_out  = wr_data_q;
    assign rd_data_out  = mem_dout_in;

    assign rd_data_valid_out = rd_vld_q[RD_LAT-1];
    assign state_out         = state_q;
    assign frame_ready_out   = frame_ready_q;
    assign short_frame_out   = short_q;
`ifdef CAPTURE_TIMEOUT_EN
    assign timeout_out       = timeout_q;
`else
    assign timeout_out       = 1'b0;
`endif

    // Next-state, write stage and counters
    always_comb begin
        state_d   = state_q;
        short_d   = short_q;
        we_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pix_cnt_d = pix_cnt_q;
        // Truncating cast keeps the low RD_LAT bits, so RD_LAT=1 needs no special case
        rd_vld_d  = RD_LAT'({rd_vld_q, rd_grant_out});
`ifdef CAPTURE_TIMEOUT_EN
        tmo_cnt_d = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (capture_req_in) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (frame_done_in) begin
                    state_d   = ST_CAPTURE;
                    pix_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                // A pixel coinciding with the frame boundary is dropped
                if (frame_done_in) begin
                    state_d = ST_HOLD;
                    short_d = (pix_cnt_q != FRAME_PIX);
                end else if (pix_ok) begin
                    we_pend_d = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = pixel_in;
                    if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (release_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef CAPTURE_TIMEOUT_EN
        // Watchdog: a simultaneous frame boundary takes precedence
        if (state_q == ST_ARMED || state_q == ST_CAPTURE) begin
            if (!frame_done_in && tmo_cnt_q == TMO_LAST) begin
                state_d   = ST_IDLE;
                we_pend_d = 1'b0;
                timeout_d = 1'b1;
            end else if (state_d == state_q) begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
`endif
    end

    assign frame_ready_d = (state_d == ST_HOLD);

    // State and pipeline registers
    always_ff @(posedge system_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            frame_ready_q <= 1'b0;
            short_q       <= 1'b0;
            we_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            pix_cnt_q     <= '0;
            rd_vld_q      <= '0;
`ifdef CAPTURE_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_ready_q <= frame_ready_d;
            short_q       <= short_d;
            we_pend_q     <= we_pend_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            pix_cnt_q     <= pix_cnt_d;
            rd_vld_q      <= rd_vld_d;
`ifdef CAPTURE_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized bench for frame_capture_ctrl. It uses a 4x2 frame with a behavioural BRAM.
// A transaction-level model keeps expected writes and reads in queues, and a
// golden frame image.
module tb_frame_capture_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int AW  = 18;
    localparam int RL  = 2;
    localparam int TMO = 50;

    logic          clk;
    logic          rst;
    logic          capture_req, rel, frame_done, data_valid;
    logic [15:0]   pixel;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_grant_out, rd_data_valid_out, mem_we_out;
    logic [15:0]   rd_data_out, mem_din_out, mem_dout;
    logic [AW-1:0] mem_addr_out;
    logic [1:0]    state_out;
    logic          frame_ready_out, short_frame_out, timeout_out;

    frame_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RD_LAT(RL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .system_clk_in     (clk),
        .rst_in            (rst),
        .capture_req_in    (capture_req),
        .release_in        (rel),
        .frame_done_in     (frame_done),
        .data_valid_in     (data_valid),
        .pixel_in          (pixel),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .rd_req_in         (rd_req),
        .rd_addr_in        (rd_addr),
        .rd_grant_out      (rd_grant_out),
        .rd_data_valid_out (rd_data_valid_out),
        .rd_data_out       (rd_data_out),
        .mem_addr_out      (mem_addr_out),
        .mem_we_out        (mem_we_out),
        .mem_din_out       (mem_din_out),
        .mem_dout_in       (mem_dout),
        .state_out         (state_out),
        .frame_ready_out   (frame_ready_out),
        .short_frame_out   (short_frame_out),
        .timeout_out       (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Behavioural BRAM with RL-cycle registered read
    logic [15:0] bram [256];
    logic [15:0] rd_pipe [RL];
    initial for (int i = 0; i < 256; i++) bram[i] = 16'h0;
    always @(posedge clk) begin
        if (mem_we_out) bram[mem_addr_out[7:0]] <= mem_din_out;
        rd_pipe[0] <= bram[mem_addr_out[7:0]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RL-1];

    // Reference model state
    typedef struct { int addr; logic [15:0] data; logic [15:0] old; int due; } wr_t;
    typedef struct { logic [15:0] data; int due; } rd_t;
    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [15:0] gold [W*H];
    int          m_state = 0;
    int          m_cnt   = 0;
    bit          m_short = 1'b0;
    bit          pend_m  = 1'b0;

    // Write monitor: each accepted pixel must hit the BRAM exactly one cycle later
    always @(negedge clk) begin : wr_mon
        wr_t w;
        if (mem_we_out) begin
            if (exp_wr.size() == 0) chk("unexpected_write", 32'(mem_we_out), 32'd0);
            else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_addr_out), 32'(w.addr));
                chk("wr_data", 32'(mem_din_out), 32'(w.data));
                chk("wr_cycle", 32'(cyc), 32'(w.due));
            end
        end else if (exp_wr.size() != 0 && exp_wr[0].due <= cyc) begin
            w = exp_wr.pop_front();
            chk("missing_write", 32'(mem_we_out), 32'd1);
        end
    end

    // Read monitor: data valid exactly RL cycles after grant
    always @(negedge clk) begin : rd_mon
        rd_t r;
        if (rd_data_valid_out) begin
            if (exp_rd.size() == 0) chk("unexpected_rd_valid", 32'(rd_data_valid_out), 32'd0);
            else begin
                r = exp_rd.pop_front();
                chk("rd_data", 32'(rd_data_out), 32'(r.data));
                chk("rd_cycle", 32'(cyc), 32'(r.due));
            end
        end else if (exp_rd.size() != 0 && exp_rd[0].due <= cyc) begin
            r = exp_rd.pop_front();
            chk("missing_rd_valid", 32'(rd_data_valid_out), 32'd1);
        end
    end

    task automatic clr();
        capture_req = 1'b0; rel = 1'b0; frame_done = 1'b0; data_valid = 1'b0;
        pixel = 16'h0; hcount = 11'h0; vcount = 10'h0; rd_req = 1'b0; rd_addr = '0;
    endtask

    task automatic raw_step();
        @(posedge clk);
        #1;
    endtask

    // One clock with current inputs; model predicts grant, writes, reads and next state
    task automatic tick();
        bit acc;
        int a;
        #1;
        if (rd_req) begin
            chk("rd_grant", 32'(rd_grant_out), 32'(!pend_m));
            if (!pend_m) begin
                chk("rd_addr_sel", 32'(mem_addr_out), 32'(rd_addr));
                exp_rd.push_back('{gold[int'(rd_addr)], cyc + RL});
            end
        end
        acc = (m_state == 2) && data_valid && (int'(hcount) < W) && (int'(vcount) < H) && !frame_done;
        if (acc) begin
            a = int'(vcount) * W + int'(hcount);
            exp_wr.push_back('{a, pixel, gold[a], cyc + 1});
            gold[a] = pixel;
            m_cnt++;
        end
        case (m_state)
            0: if (capture_req) m_state = 1;
            1: if (frame_done) begin m_state = 2; m_cnt = 0; end
            2: if (frame_done) begin m_state = 3; m_short = (m_cnt != W*H); end
            default: if (rel) m_state = 0;
        endcase
        pend_m = acc;
        raw_step();
        chk("state", 32'(state_out), 32'(m_state));
        chk("frame_ready", 32'(frame_ready_out), 32'(m_state == 3));
        chk("short_frame", 32'(short_frame_out), 32'(m_short));
        chk("timeout_idle", 32'(timeout_out), 32'd0);
    endtask

    task automatic start_capture();
        clr(); capture_req = 1'b1; tick();
        clr(); frame_done = 1'b1; tick();
        clr();
    endtask

    task automatic put_pix(input int i, input logic [15:0] px, input bit rdr);
        clr();
        data_valid = 1'b1; hcount = 11'(i % W); vcount = 10'(i / W); pixel = px;
        rd_req = rdr; rd_addr = AW'(5);
        tick();
    endtask

    task automatic end_frame();
        clr(); frame_done = 1'b1; tick(); clr();
    endtask

    task automatic do_release();
        clr(); rel = 1'b1; tick(); clr();
    endtask

    task automatic rnd_rd();
        rd_req  = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom_range(0, W*H-1));
    endtask

    task automatic rnd_capture(input bit full);
        int n;
        clr(); capture_req = 1'b1; frame_done = 1'($urandom_range(0, 1)); tick();
        repeat ($urandom_range(0, 3)) begin
            clr(); rnd_rd(); capture_req = 1'($urandom_range(0, 1));
            data_valid = 1'b1; hcount = 11'($urandom_range(0, W-1)); pixel = 16'($urandom);
            tick();
        end
        clr(); frame_done = 1'b1; data_valid = 1'($urandom_range(0, 1)); tick();
        n = full ? W*H : int'($urandom_range(0, W*H-1));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                clr(); rnd_rd(); data_valid = 1'b1; pixel = 16'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    hcount = 11'(W + int'($urandom_range(0, 3))); vcount = 10'(i / W);
                end else begin
                    hcount = 11'(i % W); vcount = 10'(H + int'($urandom_range(0, 3)));
                end
                tick();
            end
            if ($urandom_range(0, 3) == 0) begin
                clr(); rnd_rd(); capture_req = 1'($urandom_range(0, 1)); tick();
            end
            clr(); rnd_rd();
            data_valid = 1'b1; hcount = 11'(i % W); vcount = 10'(i / W); pixel = 16'($urandom);
            tick();
        end
        clr(); frame_done = 1'b1; data_valid = 1'($urandom_range(0, 1)); pixel = 16'($urandom);
        tick();
        repeat ($urandom_range(2, 5)) begin
            clr(); rd_req = 1'b1; rd_addr = AW'($urandom_range(0, W*H-1));
            frame_done = 1'($urandom_range(0, 1)); capture_req = 1'($urandom_range(0, 1));
            data_valid = 1'($urandom_range(0, 1));
            tick();
        end
        do_release();
    endtask

    initial begin : main
        wr_t w;
        for (int i = 0; i < W*H; i++) gold[i] = 16'h0;
        clr();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready_out), 32'd0);
        chk("rst_short", 32'(short_frame_out), 32'd0);
        chk("rst_timeout", 32'(timeout_out), 32'd0);
        chk("rst_we", 32'(mem_we_out), 32'd0);
        chk("rst_rd_valid", 32'(rd_data_valid_out), 32'd0);
        chk("rst_din", 32'(mem_din_out), 32'd0);
        chk("rst_addr", 32'(mem_addr_out), 32'd0);
        rst = 1'b0;
        clr(); tick();

        // Full directed frame with a read held across the pending writes
        start_capture();
        for (int i = 0; i < W*H; i++) begin
            put_pix(i, 16'(16'h0100 + i), 1'b1);
            if (i == 3) begin clr(); rd_req = 1'b1; rd_addr = AW'(5); tick(); end
        end
        end_frame();
        chk("hold_short_clear", 32'(short_frame_out), 32'd0);
        clr(); rd_req = 1'b1; rd_addr = AW'(5); tick();
        clr(); repeat (RL + 1) tick();
        chk("gold_addr5", 32'(gold[5]), 32'h0105);
        do_release();

        // Short frame with an out-of-range column strobe
        start_capture();
        for (int i = 0; i < 6; i++) begin
            put_pix(i, 16'(16'h0200 + i), 1'b0);
            if (i == 2) begin
                clr(); data_valid = 1'b1; hcount = 11'(4); vcount = 10'(0); pixel = 16'hDEAD; tick();
            end
        end
        end_frame();
        chk("short_set", 32'(short_frame_out), 32'd1);

        // HOLD ignores request and frame boundary together
        clr(); capture_req = 1'b1; frame_done = 1'b1; tick();
        do_release();
        chk("released_ready", 32'(frame_ready_out), 32'd0);

        // Reset in the middle of a capture, with a write still staged
        start_capture();
        put_pix(0, 16'h0A00, 1'b0);
        put_pix(1, 16'h0A01, 1'b0);
        rst = 1'b1;
        while (exp_wr.size() != 0) begin
            w = exp_wr.pop_back();
            gold[w.addr] = w.old;
        end
        exp_rd.delete();
        #1;
        chk("midrst_state", 32'(state_out), 32'd0);
        chk("midrst_we", 32'(mem_we_out), 32'd0);
        chk("midrst_ready", 32'(frame_ready_out), 32'd0);
        raw_step();
        rst = 1'b0;
        m_state = 0; m_short = 1'b0; pend_m = 1'b0;
        repeat (8) begin
            clr(); data_valid = 1'b1; hcount = 11'($urandom_range(0, W-1));
            frame_done = 1'($urandom_range(0, 1)); pixel = 16'($urandom);
            tick();
        end

        // Randomized captures
        for (int k = 0; k < 16; k++) rnd_capture(1'($urandom_range(0, 2) != 0));

`ifdef CAPTURE_TIMEOUT_EN
        // Watchdog fires after TMO cycles in ARMED
        clr(); capture_req = 1'b1; tick(); clr();
        for (int k = 1; k < TMO; k++) begin
            raw_step();
            chk("tmo_armed_state", 32'(state_out), 32'd1);
            chk("tmo_no_pulse", 32'(timeout_out), 32'd0);
        end
        raw_step();
        chk("tmo_state_idle", 32'(state_out), 32'd0);
        chk("tmo_pulse", 32'(timeout_out), 32'd1);
        raw_step();
        chk("tmo_pulse_end", 32'(timeout_out), 32'd0);
        m_state = 0;
        // Frame boundary on the watchdog cycle wins
        clr(); capture_req = 1'b1; tick(); clr();
        for (int k = 1; k < TMO; k++) raw_step();
        frame_done = 1'b1;
        raw_step();
        frame_done = 1'b0;
        chk("tmo_fd_state", 32'(state_out), 32'd2);
        chk("tmo_fd_no_pulse", 32'(timeout_out), 32'd0);
        m_state = 2; m_cnt = 0;
        end_frame();
        do_release();
`endif

        clr(); repeat (RL + 2) tick();
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
